// File: rtl/pipe_share_arb.sv
// pipe_share_arb: shares one in-order, fixed-latency valid/ready pipeline
// between NUM_REQ requesters.
//  - The input side is a round-robin arbiter with zero added latency.
//  - Each granted requester ID is pushed into a tag FIFO.
//  - The FIFO head steers every pipeline result back to its originator.
// Optional: define PIPE_SHARE_ARB_STATS_EN to add saturating per-requester
// grant counters (grant_cnt_o) with a synchronous clear (stats_clr_i).

`ifdef PIPE_SHARE_ARB_STATS_EN
// Saturating 16-bit grant counter for one requester; clear beats increment.
module pipe_share_arb_cnt (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);
    logic [15:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule
`endif

module pipe_share_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 5,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [NUM_REQ*DATA_W-1:0]   req_val_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_rdy_o,
    output logic [DATA_W-1:0]           pipe_in_val_o,
    output logic                        pipe_in_valid_o,
    input  logic                        pipe_in_rdy_i,
    input  logic [DATA_W-1:0]           pipe_out_val_i,
    input  logic                        pipe_out_valid_i,
    output logic                        pipe_out_rdy_o,
    output logic [DATA_W-1:0]           rsp_val_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    input  logic [NUM_REQ-1:0]          rsp_rdy_i,
    output logic                        busy_o,
    output logic                        err_o
`ifdef PIPE_SHARE_ARB_STATS_EN
    ,
    input  logic                        stats_clr_i,
    output logic [NUM_REQ*16-1:0]       grant_cnt_o
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = $clog2(TAG_DEPTH);
    localparam int CW   = AW + 1;

    typedef logic [ID_W-1:0] id_t;

    logic [NUM_REQ-1:0][DATA_W-1:0] req_pay;
    assign req_pay = req_val_i;

    id_t           rr_ptr_q, rr_ptr_d;
    id_t           grant;
    id_t           head;
    logic          found;
    logic          any_req;
    logic          tag_full, tag_empty;
    logic          push, pop;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    id_t           tag_mem_q [TAG_DEPTH];
    id_t           tag_mem_d [TAG_DEPTH];
    logic          err_q, err_d;

    assign any_req   = |req_valid_i;
    assign tag_full  = (count_q == CW'(TAG_DEPTH));
    assign tag_empty = (count_q == '0);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid_i[j[ID_W-1:0]]) begin
                found = 1'b1;
                grant = id_t'(j);
            end
        end
    end

    // Input side: valid ignores downstream ready; everything gated by reset
    // so no handshake is visible while reset_ni is low.
    assign pipe_in_valid_o = reset_ni && any_req && !tag_full;
    assign pipe_in_val_o   = req_pay[grant];
    assign push            = pipe_in_valid_o && pipe_in_rdy_i;

    // One-hot request ready to the granted requester only.
    always_comb begin
        req_rdy_o = '0;
        if (push) req_rdy_o[grant] = 1'b1;
    end

    // Output side: the FIFO head owns the current pipeline result.
    assign head           = tag_mem_q[rd_ptr_q];
    assign rsp_val_o      = pipe_out_val_i;
    assign pipe_out_rdy_o = reset_ni && !tag_empty && rsp_rdy_i[head];
    assign pop            = pipe_out_valid_i && pipe_out_rdy_o;

    // One-hot response valid towards the head requester.
    always_comb begin
        rsp_valid_o = '0;
        if (reset_ni && pipe_out_valid_i && !tag_empty) rsp_valid_o[head] = 1'b1;
    end

    // Next-state for arbiter pointer, tag FIFO and sticky error.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tag_mem_d = tag_mem_q;
        err_d     = err_q | (pipe_out_valid_i && tag_empty);
        if (push) begin
            tag_mem_d[wr_ptr_q] = grant;
            wr_ptr_d            = wr_ptr_q + AW'(1);
            rr_ptr_d            = (grant == id_t'(NUM_REQ - 1)) ? '0 : grant + id_t'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        // Simultaneous push/pop leaves the occupancy unchanged.
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    // State registers; in-flight tags are dropped on reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tag_mem_q <= tag_mem_d;
        end
    end

    assign busy_o = !tag_empty;
    assign err_o  = err_q;

`ifdef PIPE_SHARE_ARB_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        pipe_share_arb_cnt u_cnt (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .clr_i    (stats_clr_i),
            .inc_i    (push && (grant == id_t'(k))),
            .cnt_o    (grant_cnt_o[k*16 +: 16])
        );
    end
`endif
endmodule

// File: doc/pipe_share_arb.md
Name: pipe_share_arb

Overview:
- Shares one valid/ready processing pipeline (single input port, single output port, in-order, fixed multi-stage latency) between NUM_REQ requesters.
- Performs round-robin arbitration on the pipeline input.
- Records the granted requester ID in a tag FIFO and steers each pipeline result back to its originating requester.
- Sits between the requester clients and the pipeline instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 5, data width of requests, pipeline payload and responses.
- TAG_DEPTH, 8, tag FIFO depth; power of 2; must be >= pipeline stage count + 2.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- reset_ni  input  1  asynchronous active-low reset.
- req_val_i  input  NUM_REQ*DATA_W  request payloads; requester k uses bits [k*DATA_W +: DATA_W].
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_rdy_o  output  NUM_REQ  per-requester request accepted.
- pipe_in_val_o  output  DATA_W  payload to pipeline input.
- pipe_in_valid_o  output  1  valid to pipeline input.
- pipe_in_rdy_i  input  1  ready from pipeline input.
- pipe_out_val_i  input  DATA_W  pipeline result.
- pipe_out_valid_i  input  1  pipeline result valid.
- pipe_out_rdy_o  output  1  ready to pipeline output.
- rsp_val_o  output  DATA_W  response payload, shared by all requesters.
- rsp_valid_o  output  NUM_REQ  one-hot response valid.
- rsp_rdy_i  input  NUM_REQ  per-requester response ready.
- busy_o  output  1  tag FIFO non-empty (items in flight).
- err_o  output  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr = 0; tag FIFO empty (rd_ptr = wr_ptr = 0, count = 0); err_o = 0.
  - All handshake outputs = 0 while reset_ni is low.
- Arbitration is combinational and adds zero cycles:
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the first asserted req_valid_i bit is the grant g.
  - pipe_in_valid_o = |req_valid_i && !tag_full.
  - pipe_in_val_o = payload of g.
  - req_rdy_o[g] = pipe_in_rdy_i && !tag_full; all other req_rdy_o bits = 0.
  - pipe_in_valid_o never depends on pipe_in_rdy_i.
- Accept: pipe_in_valid_o && pipe_in_rdy_i.
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - With no accept, rr_ptr holds, so the grant is stable while a requester is stalled.
- Response steering:
  - head = tag FIFO head.
  - rsp_val_o = pipe_out_val_i.
  - rsp_valid_o[head] = pipe_out_valid_i && !tag_empty; other bits = 0.
  - pipe_out_rdy_o = rsp_rdy_i[head] && !tag_empty.
  - Pop the tag FIFO on pipe_out_valid_i && pipe_out_rdy_o.
- Tag FIFO:
  - Pointers are log2(TAG_DEPTH) bits and wrap naturally.
  - count is log2(TAG_DEPTH)+1 bits.
  - tag_full = (count == TAG_DEPTH); tag_empty = (count == 0).
- Boundary conditions:
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - When full, push is blocked even if a pop occurs that cycle; no combinational full-to-pop bypass.
  - Pop when empty is impossible, because pipe_out_rdy_o = 0 while empty.
- Error: pipe_out_valid_i while tag_empty sets err_o = 1. err_o clears only on reset.
- Ordering: the pipeline is in-order, so results return in grant order; per-requester ordering is preserved.
- Back-pressure from a slow response consumer stalls the pipeline output only; the arbiter keeps granting until tag_full.
- Reset mid-operation: in-flight tags are discarded; the pipeline is reset by the same reset.

Optional Feature:
- Macro: PIPE_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt_o, width NUM_REQ*16: one 16-bit counter per requester.
  - A counter increments on each accept for that requester and saturates at 16'hFFFF.
  - Adds input stats_clr_i, 1 bit; synchronous clear of all counters. If clear and accept occur in the same cycle, clear wins.
  - Counters reset to 0.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Single requester: req_valid_i=4'b0100, payload 3; pipe_in_rdy_i=1 -> req_rdy_o=4'b0100, pipe_in_val_o=3; when pipe_out_val_i=8 returns, rsp_valid_o=4'b0100 and rsp_val_o=8; busy_o returns to 0 after the pop.
- All four requesting continuously with pipe_in_rdy_i=1 -> grant order 0,1,2,3,0,...; responses return with one-hot rsp_valid_o in the same order.
- pipe_in_rdy_i=0 for 3 cycles while requesters 1 and 2 are valid -> grant held on requester 1, rr_ptr unchanged; once ready, requester 1 is accepted, then requester 2.
- rsp_rdy_i=0 for the head requester for 20 cycles -> exactly TAG_DEPTH=8 accepts occur, then pipe_in_valid_o=0; after release, all 8 responses drain in order.
- Inject pipe_out_valid_i=1 with the FIFO empty -> err_o=1 next cycle and sticky; reset_ni low asynchronously -> err_o=0, busy_o=0 and all ready/valid outputs 0 immediately.
- With STATS_EN defined, 5 grants to requester 0 and 2 grants to requester 3 -> counts {3:2, 2:0, 1:0, 0:5}; stats_clr_i pulsed in the same cycle as an accept -> all counters 0.
